// File: rtl/control_sequencer_if.sv
// Control bundle between control_sequencer and the datapath: the decoded
// instruction inputs plus every load enable, bus select and memory strobe.
interface control_sequencer_if;
    logic [31:0] IR;
    logic        CON;
    logic        Stop;

    logic HIin, LOin, PCin, MDRin, Zin, Yin, MARin, IRin, CONin, OUTPORTin;
    logic HIout, LOout, ZHIout, ZLOout, PCout, MDRout, INPORTout, Cout;
    logic Gra, Grb, Grc, Rin, Rout, BAout;
    logic Read, write, IncPC;
    logic ALUadd;
    logic Run;
    logic [4:0] Present_state;

    modport master (
        input  IR, CON, Stop,
        output HIin, LOin, PCin, MDRin, Zin, Yin, MARin, IRin, CONin, OUTPORTin,
        output HIout, LOout, ZHIout, ZLOout, PCout, MDRout, INPORTout, Cout,
        output Gra, Grb, Grc, Rin, Rout, BAout,
        output Read, write, IncPC, ALUadd, Run, Present_state
    );

    modport slave (
        output IR, CON, Stop,
        input  HIin, LOin, PCin, MDRin, Zin, Yin, MARin, IRin, CONin, OUTPORTin,
        input  HIout, LOout, ZHIout, ZLOout, PCout, MDRout, INPORTout, Cout,
        input  Gra, Grb, Grc, Rin, Rout, BAout,
        input  Read, write, IncPC, ALUadd, Run, Present_state
    );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired control unit: fetch (T0-T2) plus per-opcode execute steps (T3-T7),
// with every strobe a registered Moore decode of the state being entered.
module control_sequencer (
    input  logic                Clock,
    input  logic                Reset_n,
    control_sequencer_if.master bus
);

    typedef enum logic [4:0] {
        RESET_ST = 5'd0,
        T0       = 5'd1,
        T1       = 5'd2,
        T2       = 5'd3,
        T3       = 5'd4,
        T4       = 5'd5,
        T5       = 5'd6,
        T6       = 5'd7,
        T7       = 5'd8,
        HALT     = 5'd9
    } state_t;

    typedef enum logic [3:0] {
        C_NOP  = 4'd0,
        C_LD   = 4'd1,
        C_LDI  = 4'd2,
        C_ST   = 4'd3,
        C_R    = 4'd4,
        C_ADDI = 4'd5,
        C_BR   = 4'd6,
        C_JR   = 4'd7,
        C_JAL  = 4'd8,
        C_IN   = 4'd9,
        C_OUT  = 4'd10,
        C_MFHI = 4'd11,
        C_MFLO = 4'd12,
        C_HALT = 4'd13
    } op_class_t;

    typedef struct packed {
        logic hi_in, lo_in, pc_in, mdr_in, z_in, y_in, mar_in, ir_in, con_in, outport_in;
        logic hi_out, lo_out, zhi_out, zlo_out, pc_out, mdr_out, inport_out, c_out;
        logic gra, grb, grc, r_in, r_out, ba_out;
        logic read, write, inc_pc, alu_add;
        logic br_pc;
    } ctrl_t;

    function automatic op_class_t classify(input logic [4:0] op);
        op_class_t c;
        case (op)
            5'b00000: c = C_LD;
            5'b00001: c = C_LDI;
            5'b00010: c = C_ST;
            5'b00011, 5'b00100, 5'b00101, 5'b00110: c = C_R;
            5'b01100: c = C_ADDI;
            5'b10010: c = C_BR;
            5'b10011: c = C_JR;
            5'b10100: c = C_JAL;
            5'b10101: c = C_IN;
            5'b10110: c = C_OUT;
            5'b10111: c = C_MFHI;
            5'b11000: c = C_MFLO;
            5'b11010: c = C_HALT;
            default:  c = C_NOP;
        endcase
        return c;
    endfunction

    function automatic state_t last_step(input op_class_t c);
        state_t s;
        case (c)
            C_LD, C_ST:                                  s = T7;
            C_BR:                                        s = T6;
            C_LDI, C_R, C_ADDI:                          s = T5;
            C_JAL:                                       s = T4;
            C_JR, C_IN, C_OUT, C_MFHI, C_MFLO, C_HALT:   s = T3;
            default:                                     s = T2;
        endcase
        return s;
    endfunction

    function automatic ctrl_t decode(input state_t st, input op_class_t c);
        ctrl_t d;
        d = '0;
        case (st)
            T0: begin d.pc_out = 1'b1; d.mar_in = 1'b1; end
            T1: begin d.read = 1'b1; d.mdr_in = 1'b1; d.pc_in = 1'b1; d.inc_pc = 1'b1; end
            T2: begin d.mdr_out = 1'b1; d.ir_in = 1'b1; end
            T3: begin
                case (c)
                    C_LD, C_LDI, C_ST: begin d.grb = 1'b1; d.r_out = 1'b1; d.ba_out = 1'b1; d.y_in = 1'b1; end
                    C_R, C_ADDI:       begin d.grb = 1'b1; d.r_out = 1'b1; d.y_in = 1'b1; end
                    C_BR:              begin d.gra = 1'b1; d.r_out = 1'b1; d.con_in = 1'b1; end
                    C_JR:              begin d.gra = 1'b1; d.r_out = 1'b1; d.pc_in = 1'b1; end
                    C_JAL:             begin d.pc_out = 1'b1; d.grb = 1'b1; d.r_in = 1'b1; end
                    C_IN:              begin d.inport_out = 1'b1; d.gra = 1'b1; d.r_in = 1'b1; end
                    C_OUT:             begin d.gra = 1'b1; d.r_out = 1'b1; d.outport_in = 1'b1; end
                    C_MFHI:            begin d.hi_out = 1'b1; d.gra = 1'b1; d.r_in = 1'b1; end
                    C_MFLO:            begin d.lo_out = 1'b1; d.gra = 1'b1; d.r_in = 1'b1; end
                    default:           d = '0;
                endcase
            end
            T4: begin
                case (c)
                    C_LD, C_LDI, C_ST, C_ADDI: begin d.c_out = 1'b1; d.alu_add = 1'b1; d.z_in = 1'b1; end
                    C_R:               begin d.grc = 1'b1; d.r_out = 1'b1; d.z_in = 1'b1; end
                    C_BR:              begin d.pc_out = 1'b1; d.y_in = 1'b1; end
                    C_JAL:             begin d.gra = 1'b1; d.r_out = 1'b1; d.pc_in = 1'b1; end
                    default:           d = '0;
                endcase
            end
            T5: begin
                case (c)
                    C_LD, C_ST:        begin d.zlo_out = 1'b1; d.mar_in = 1'b1; end
                    C_LDI, C_R, C_ADDI: begin d.zlo_out = 1'b1; d.gra = 1'b1; d.r_in = 1'b1; end
                    C_BR:              begin d.c_out = 1'b1; d.alu_add = 1'b1; d.z_in = 1'b1; end
                    default:           d = '0;
                endcase
            end
            T6: begin
                case (c)
                    C_LD:              begin d.read = 1'b1; d.mdr_in = 1'b1; end
                    C_ST:              begin d.gra = 1'b1; d.r_out = 1'b1; d.mdr_in = 1'b1; end
                    C_BR:              begin d.zlo_out = 1'b1; d.br_pc = 1'b1; end
                    default:           d = '0;
                endcase
            end
            T7: begin
                case (c)
                    C_LD:              begin d.mdr_out = 1'b1; d.gra = 1'b1; d.r_in = 1'b1; end
                    C_ST:              d.write = 1'b1;
                    default:           d = '0;
                endcase
            end
            default: d = '0;
        endcase
        return d;
    endfunction

    state_t    state_r;
    op_class_t class_r;
    ctrl_t     ctrl_r;
    logic      run_r;

    op_class_t cur_class_s;
    state_t    next_state_s;
    ctrl_t     next_ctrl_s;
    logic      unused_ir_s;

    assign unused_ir_s = ^bus.IR[26:0];

    // Next-state logic; during T2 the opcode comes straight from IR, afterwards from the latch.
    always_comb begin
        next_state_s = RESET_ST;
        if (state_r == T2) begin
            cur_class_s = classify(bus.IR[31:27]);
        end else begin
            cur_class_s = class_r;
        end
        case (state_r)
            RESET_ST: next_state_s = T0;
            T0, T1:   next_state_s = state_t'(state_r + 5'd1);
            T2, T3, T4, T5, T6, T7: begin
                if (state_r == last_step(cur_class_s)) begin
                    if ((cur_class_s == C_HALT) || bus.Stop) begin
                        next_state_s = HALT;
                    end else begin
                        next_state_s = T0;
                    end
                end else begin
                    next_state_s = state_t'(state_r + 5'd1);
                end
            end
            HALT:     next_state_s = HALT;
            default:  next_state_s = RESET_ST;
        endcase
        next_ctrl_s = decode(next_state_s, cur_class_s);
    end

    // Sequencer state, opcode latch and registered strobes for the step being entered.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r <= RESET_ST;
            class_r <= C_NOP;
            ctrl_r  <= '0;
            run_r   <= 1'b0;
        end else begin
            state_r <= next_state_s;
            if (state_r == T2) begin
                class_r <= cur_class_s;
            end
            ctrl_r  <= next_ctrl_s;
            run_r   <= (next_state_s != RESET_ST) && (next_state_s != HALT);
        end
    end

    // The only combinational input path: branch taken when CON is high during br T6.
    assign bus.PCin          = ctrl_r.pc_in | (ctrl_r.br_pc & bus.CON);
    assign bus.HIin          = ctrl_r.hi_in;
    assign bus.LOin          = ctrl_r.lo_in;
    assign bus.MDRin         = ctrl_r.mdr_in;
    assign bus.Zin           = ctrl_r.z_in;
    assign bus.Yin           = ctrl_r.y_in;
    assign bus.MARin         = ctrl_r.mar_in;
    assign bus.IRin          = ctrl_r.ir_in;
    assign bus.CONin         = ctrl_r.con_in;
    assign bus.OUTPORTin     = ctrl_r.outport_in;
    assign bus.HIout         = ctrl_r.hi_out;
    assign bus.LOout         = ctrl_r.lo_out;
    assign bus.ZHIout        = ctrl_r.zhi_out;
    assign bus.ZLOout        = ctrl_r.zlo_out;
    assign bus.PCout         = ctrl_r.pc_out;
    assign bus.MDRout        = ctrl_r.mdr_out;
    assign bus.INPORTout     = ctrl_r.inport_out;
    assign bus.Cout          = ctrl_r.c_out;
    assign bus.Gra           = ctrl_r.gra;
    assign bus.Grb           = ctrl_r.grb;
    assign bus.Grc           = ctrl_r.grc;
    assign bus.Rin           = ctrl_r.r_in;
    assign bus.Rout          = ctrl_r.r_out;
    assign bus.BAout         = ctrl_r.ba_out;
    assign bus.Read          = ctrl_r.read;
    assign bus.write         = ctrl_r.write;
    assign bus.IncPC         = ctrl_r.inc_pc;
    assign bus.ALUadd        = ctrl_r.alu_add;
    assign bus.Run           = run_r;
    assign bus.Present_state = state_r;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: steps each instruction clock by clock and
// compares the state and the full strobe word against hand-built expectations.
module tb_control_sequencer;

    logic Clock = 1'b0;
    logic Reset_n;
    int   n_vec;
    int   n_err;

    control_sequencer_if bus ();

    control_sequencer dut (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    always #5 Clock = ~Clock;

    localparam logic [4:0] S_RST = 5'd0, S_T0 = 5'd1, S_T1 = 5'd2, S_T2 = 5'd3, S_T3 = 5'd4,
                           S_T4 = 5'd5, S_T5 = 5'd6, S_T6 = 5'd7, S_T7 = 5'd8, S_HALT = 5'd9;

    localparam logic [28:0] B_HIIN = 29'h1 << 28, B_LOIN = 29'h1 << 27, B_PCIN = 29'h1 << 26,
        B_MDRIN = 29'h1 << 25, B_ZIN = 29'h1 << 24, B_YIN = 29'h1 << 23, B_MARIN = 29'h1 << 22,
        B_IRIN = 29'h1 << 21, B_CONIN = 29'h1 << 20, B_OUTPIN = 29'h1 << 19, B_HIOUT = 29'h1 << 18,
        B_LOOUT = 29'h1 << 17, B_ZHIOUT = 29'h1 << 16, B_ZLOOUT = 29'h1 << 15, B_PCOUT = 29'h1 << 14,
        B_MDROUT = 29'h1 << 13, B_INPOUT = 29'h1 << 12, B_COUT = 29'h1 << 11, B_GRA = 29'h1 << 10,
        B_GRB = 29'h1 << 9, B_GRC = 29'h1 << 8, B_RIN = 29'h1 << 7, B_ROUT = 29'h1 << 6,
        B_BAOUT = 29'h1 << 5, B_READ = 29'h1 << 4, B_WRITE = 29'h1 << 3, B_INCPC = 29'h1 << 2,
        B_ALUADD = 29'h1 << 1, B_RUN = 29'h1;

    localparam logic [28:0] F0 = B_PCOUT | B_MARIN | B_RUN;
    localparam logic [28:0] F1 = B_READ | B_MDRIN | B_PCIN | B_INCPC | B_RUN;
    localparam logic [28:0] F2 = B_MDROUT | B_IRIN | B_RUN;
    localparam logic [28:0] LD3 = B_GRB | B_ROUT | B_BAOUT | B_YIN | B_RUN;
    localparam logic [28:0] LD4 = B_COUT | B_ALUADD | B_ZIN | B_RUN;
    localparam logic [28:0] LD5 = B_ZLOOUT | B_MARIN | B_RUN;

    wire [28:0] ctrl_obs = {bus.HIin, bus.LOin, bus.PCin, bus.MDRin, bus.Zin, bus.Yin, bus.MARin,
                            bus.IRin, bus.CONin, bus.OUTPORTin, bus.HIout, bus.LOout, bus.ZHIout,
                            bus.ZLOout, bus.PCout, bus.MDRout, bus.INPORTout, bus.Cout, bus.Gra,
                            bus.Grb, bus.Grc, bus.Rin, bus.Rout, bus.BAout, bus.Read, bus.write,
                            bus.IncPC, bus.ALUadd, bus.Run};

    task automatic check(input string tag, input logic [4:0] st, input logic [28:0] exp);
        n_vec++;
        assert (bus.Present_state === st) else begin
            n_err++;
            $error("FAIL %s state: observed %0d expected %0d", tag, bus.Present_state, st);
        end
        n_vec++;
        assert (ctrl_obs === exp) else begin
            n_err++;
            $error("FAIL %s strobes: observed %h expected %h", tag, ctrl_obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic [4:0] st, input logic [28:0] exp);
        @(posedge Clock);
        #1;
        check(tag, st, exp);
    endtask

    task automatic fetch(input string tag);
        step({tag, " T1"}, S_T1, F1);
        step({tag, " T2"}, S_T2, F2);
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        Reset_n = 1'b0;
        bus.IR   = $urandom;
        bus.CON  = 1'b0;
        bus.Stop = 1'b0;
        repeat (3) @(posedge Clock);
        #1;
        check("reset hold", S_RST, 29'h0);

        bus.IR = 32'h18918000;
        @(negedge Clock);
        Reset_n = 1'b1;
        step("release T0", S_T0, F0);

        fetch("add");
        step("add T3", S_T3, B_GRB | B_ROUT | B_YIN | B_RUN);
        step("add T4", S_T4, B_GRC | B_ROUT | B_ZIN | B_RUN);
        step("add T5", S_T5, B_ZLOOUT | B_GRA | B_RIN | B_RUN);
        step("add end", S_T0, F0);

        bus.IR = 32'h00900000;
        fetch("ld");
        step("ld T3", S_T3, LD3);
        step("ld T4", S_T4, LD4);
        step("ld T5", S_T5, LD5);
        step("ld T6", S_T6, B_READ | B_MDRIN | B_RUN);
        step("ld T7", S_T7, B_MDROUT | B_GRA | B_RIN | B_RUN);
        step("ld end", S_T0, F0);

        bus.IR = 32'h10900000;
        fetch("st");
        step("st T3", S_T3, LD3);
        step("st T4", S_T4, LD4);
        step("st T5", S_T5, LD5);
        step("st T6", S_T6, B_GRA | B_ROUT | B_MDRIN | B_RUN);
        step("st T7", S_T7, B_WRITE | B_RUN);
        step("st end", S_T0, F0);

        bus.IR  = 32'h90800014;
        bus.CON = 1'b1;
        fetch("br1");
        step("br1 T3", S_T3, B_GRA | B_ROUT | B_CONIN | B_RUN);
        step("br1 T4", S_T4, B_PCOUT | B_YIN | B_RUN);
        step("br1 T5", S_T5, B_COUT | B_ALUADD | B_ZIN | B_RUN);
        step("br1 T6", S_T6, B_ZLOOUT | B_PCIN | B_RUN);
        step("br1 end", S_T0, F0);

        bus.CON = 1'b0;
        fetch("br0");
        step("br0 T3", S_T3, B_GRA | B_ROUT | B_CONIN | B_RUN);
        step("br0 T4", S_T4, B_PCOUT | B_YIN | B_RUN);
        step("br0 T5", S_T5, B_COUT | B_ALUADD | B_ZIN | B_RUN);
        step("br0 T6", S_T6, B_ZLOOUT | B_RUN);
        step("br0 end", S_T0, F0);

        bus.IR = 32'h98000000;
        fetch("jr");
        step("jr T3", S_T3, B_GRA | B_ROUT | B_PCIN | B_RUN);
        step("jr end", S_T0, F0);

        bus.IR = 32'hA0000000;
        fetch("jal");
        step("jal T3", S_T3, B_PCOUT | B_GRB | B_RIN | B_RUN);
        step("jal T4", S_T4, B_GRA | B_ROUT | B_PCIN | B_RUN);
        step("jal end", S_T0, F0);

        bus.IR = 32'hB8000000;
        fetch("mfhi");
        step("mfhi T3", S_T3, B_HIOUT | B_GRA | B_RIN | B_RUN);
        step("mfhi end", S_T0, F0);

        bus.IR = 32'hC8000000;
        fetch("nop");
        step("nop end", S_T0, F0);

        bus.IR = 32'h40000000;
        fetch("undef");
        step("undef end", S_T0, F0);

        // Stop raised over a non-final step must be ignored; over the final step it halts.
        bus.IR = 32'h18918000;
        fetch("addstop");
        step("addstop T3", S_T3, B_GRB | B_ROUT | B_YIN | B_RUN);
        bus.Stop = 1'b1;
        step("addstop T4", S_T4, B_GRC | B_ROUT | B_ZIN | B_RUN);
        bus.Stop = 1'b0;
        step("addstop T5", S_T5, B_ZLOOUT | B_GRA | B_RIN | B_RUN);
        bus.Stop = 1'b1;
        step("addstop halt", S_HALT, 29'h0);
        bus.Stop = 1'b0;
        step("halt hold", S_HALT, 29'h0);

        bus.IR = 32'hD0000000;
        @(negedge Clock);
        Reset_n = 1'b0;
        #1;
        check("reset from halt", S_RST, 29'h0);
        @(negedge Clock);
        Reset_n = 1'b1;
        step("halt T0", S_T0, F0);
        fetch("halt");
        step("halt T3", S_T3, B_RUN);
        for (int i = 0; i < 20; i++) begin
            step("halt idle", S_HALT, 29'h0);
        end

        bus.IR = 32'h00900000;
        @(negedge Clock);
        Reset_n = 1'b0;
        #1;
        check("reset again", S_RST, 29'h0);
        @(negedge Clock);
        Reset_n = 1'b1;
        step("ldr T0", S_T0, F0);
        fetch("ldr");
        step("ldr T3", S_T3, LD3);
        step("ldr T4", S_T4, LD4);
        step("ldr T5", S_T5, LD5);
        #1;
        Reset_n = 1'b0;
        #1;
        check("async reset mid-op", S_RST, 29'h0);
        @(negedge Clock);
        Reset_n = 1'b1;
        step("restart T0", S_T0, F0);
        step("restart T1", S_T1, F1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Hardwired control unit for the 32-bit bus-based datapath. It walks each instruction through fetch (T0–T2) and per-opcode execute steps (T3–T7). In each step it drives the datapath's register-enable, bus-source, memory and register-select strobes from `IR[31:27]` and `CON`. It replaces the hand-driven stimulus sequences and sits beside `datapath`, with all control outputs wired to its like-named ports.

## Interface
- `PC_WIDTH_UNUSED` — none; the block has no parameters. Encodings are fixed.
- `Clock  in  1` — system clock. All state changes on the rising edge.
- `Reset_n  in  1` — asynchronous, active-low reset.
- `IR  in  32` — instruction register contents. Only `[31:27]` (opcode) is decoded here.
- `CON  in  1` — branch condition flag from the CON FF logic.
- `Stop  in  1` — halt request. Level-sensitive, sampled at the last step of each instruction.
- `HIin, LOin, PCin, MDRin, Zin, Yin, MARin, IRin, CONin, OUTPORTin  out  1 each` — register load enables.
- `HIout, LOout, ZHIout, ZLOout, PCout, MDRout, INPORTout, Cout  out  1 each` — bus source selects.
- `Gra, Grb, Grc, Rin, Rout, BAout  out  1 each` — register-file select/encode strobes.
- `Read, write, IncPC  out  1 each` — memory read/write and PC increment.
- `ALUadd  out  1` — forces ALU to ADD regardless of opcode (address and branch-target calculation).
- `Run  out  1` — high while sequencing, low in RESET_ST and HALT.
- `Present_state  out  5` — current state encoding, for debug.

## Operation
- Opcodes:
  - 00000 ld, 00001 ldi, 00010 st
  - 00011 add, 00100 sub, 00101 and, 00110 or (R-type)
  - 01100 addi, 10010 br, 10011 jr, 10100 jal
  - 10101 in, 10110 out, 10111 mfhi, 11000 mflo
  - 11001 nop, 11010 halt
  - Any other opcode executes as nop.
- States: RESET_ST=0, T0=1 … T7=8, HALT=9.
- Fetch:
  - T0: PCout, MARin.
  - T1: Read, MDRin, PCin, IncPC.
  - T2: MDRout, IRin.
- Execute steps (unlisted steps assert nothing; last listed step is the instruction's final step):
  - ld: T3 Grb Rout BAout Yin; T4 Cout ALUadd Zin; T5 ZLOout MARin; T6 Read MDRin; T7 MDRout Gra Rin.
  - ldi: T3 Grb Rout BAout Yin; T4 Cout ALUadd Zin; T5 ZLOout Gra Rin.
  - st: T3–T5 as ld; T6 Gra Rout MDRin; T7 write.
  - R-type: T3 Grb Rout Yin; T4 Grc Rout Zin; T5 ZLOout Gra Rin.
  - addi: T3 Grb Rout Yin; T4 Cout ALUadd Zin; T5 ZLOout Gra Rin.
  - br: T3 Gra Rout CONin; T4 PCout Yin; T5 Cout ALUadd Zin; T6 ZLOout, plus PCin only if CON=1 during T6.
  - jr: T3 Gra Rout PCin.
  - jal: T3 PCout Grb Rin; T4 Gra Rout PCin.
  - in: T3 INPORTout Gra Rin.
  - out: T3 Gra Rout OUTPORTin.
  - mfhi: T3 HIout Gra Rin.
  - mflo: T3 LOout Gra Rin.
  - nop and undefined opcodes: final step is T2.
  - halt: T3 asserts nothing, then → HALT.
- Transitions:
  - RESET_ST → T0.
  - Tn → Tn+1 until the final step.
  - Final step → T0, or → HALT if `Stop`=1 at that edge.
  - HALT is absorbing; only reset leaves it.

## Timing
- Outputs are a registered Moore decode of the state. Each step lasts exactly one clock and its strobes are high from one rising edge to the next.
- Outputs are glitch-free. No input combinationally reaches any output except `CON`→`PCin` in br T6.
- Opcode is decoded from `IR` at the T2→T3 edge; IR loads at the end of T2.
- Instruction latency in clocks: nop 3; jr/in/out/mfhi/mflo 4; jal 5; R-type/addi/ldi 6; br 7; ld/st 8.
- `Reset_n` low, at any time including mid-instruction: immediately state=RESET_ST, every output 0, `Run`=0.
- The first T0 occurs on the first rising edge after `Reset_n` rises.
- `Stop` is ignored except at final-step edges. A `Stop` pulse that does not overlap a final step is lost.
- Memory is single-cycle: `Read` data is valid for MDRin in the same step.

## Test plan
- Reset: hold `Reset_n`=0 for 3 clocks with random IR → all outputs 0, `Present_state`=0. Release → T0 on the next edge with PCout=MARin=1.
- Fetch + add, IR=0x18918000 (add R1,R2,R3) → T0–T5 strobes exactly as listed, then T0 again. Total 6 clocks.
- ld/st, IR=0x00900000 then IR=0x10900000 → Read only in T1/T6 for ld; write only in T7 for st. 8 clocks each.
- br, IR=0x90800014:
  - CON=1 → PCin high during T6.
  - CON=0 → PCin low throughout T3–T6.
  - Next state T0 in both cases.
- Halt/stop:
  - IR=0xD0000000 → HALT after T3, `Run`=0, no further strobes for 20 clocks.
  - `Stop`=1 during add T5 → HALT.
- Reset mid-op: drop `Reset_n` during ld T5 → outputs zero within the same cycle (asynchronously). After release, fetch restarts at T0.
